// File: rtl/imem_fetch.sv
// Programmable instruction memory: loader writes in PROG, registered fetch port in RUN.
// Fetch latency 1 cycle; response held while rsp_ready is low, which also gates req_ready.
module imem_fetch #(
  parameter int unsigned         DATA_W    = 8,
  parameter int unsigned         ADDR_W    = 8,
  parameter int unsigned         DEPTH     = 32,
  parameter logic [DATA_W-1:0]   NOP_WORD  = '0,
  parameter                      INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_mode,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_err,
  output logic [ADDR_W-1:0] ld_count,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_instr,
  output logic              rsp_err,
  input  logic              rsp_ready,
  output logic              in_prog
);

  localparam int unsigned       IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {RUN, DRAIN, PROG} state_t;
  state_t state;

  logic [DATA_W-1:0] mem [DEPTH];

  logic             req_in_range, ld_in_range, ld_ok, accept;
  logic [IDX_W-1:0] req_idx, ld_idx;

  assign req_in_range = ({1'b0, req_addr} < DEPTH_W);
  assign ld_in_range  = ({1'b0, ld_addr} < DEPTH_W);
  assign req_idx      = req_addr[IDX_W-1:0];
  assign ld_idx       = ld_addr[IDX_W-1:0];
  assign ld_ok        = ld_en & (state == PROG) & ld_in_range;
  assign req_ready    = (state == RUN) & (~rsp_valid | rsp_ready);
  assign accept       = req_valid & req_ready;

  // Storage is deliberately outside the reset domain so loaded code survives reset.
  always_ff @(posedge clk) begin
    if (ld_ok) mem[ld_idx] <= ld_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      in_prog   <= 1'b0;
      ld_count  <= '0;
      ld_err    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_instr <= '0;
      rsp_err   <= 1'b0;
    end else begin
      ld_err <= ld_en & ~ld_ok;
      if (ld_ok) ld_count <= ld_count + 1'b1;

      case (state)
        RUN: begin
          if (prog_mode) begin
            if (rsp_valid) begin
              state <= DRAIN;
            end else begin
              state    <= PROG;
              in_prog  <= 1'b1;
              ld_count <= '0;
            end
          end
        end
        // An already-empty response register counts as drained.
        DRAIN: begin
          if (!prog_mode) begin
            state <= RUN;
          end else if (!rsp_valid || rsp_ready) begin
            state    <= PROG;
            in_prog  <= 1'b1;
            ld_count <= '0;
          end
        end
        PROG: begin
          if (!prog_mode) begin
            state   <= RUN;
            in_prog <= 1'b0;
          end
        end
        default: begin
          state   <= RUN;
          in_prog <= 1'b0;
        end
      endcase

      if (accept) begin
        rsp_valid <= 1'b1;
        rsp_instr <= req_in_range ? mem[req_idx] : NOP_WORD;
        rsp_err   <= ~req_in_range;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch.sv
// Directed vector bench for imem_fetch: load, fetch, stall, drain, loader lockout and reset.
module tb_imem_fetch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       prog_mode, ld_en, req_valid, rsp_ready;
  logic [7:0] ld_addr, ld_data, req_addr;
  logic       ld_err, req_ready, rsp_valid, rsp_err, in_prog;
  logic [7:0] ld_count, rsp_instr;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  imem_fetch #(
    .DATA_W(8), .ADDR_W(8), .DEPTH(32), .NOP_WORD(8'h00), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .prog_mode(prog_mode),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_err(ld_err), .ld_count(ld_count),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_instr(rsp_instr), .rsp_err(rsp_err),
    .rsp_ready(rsp_ready), .in_prog(in_prog)
  );

  typedef struct {
    bit       pm, le;
    bit [7:0] la, ld;
    bit       rv;
    bit [7:0] ra;
    bit       rr;
    bit       e_rdy;
    bit       e_vld;
    bit [7:0] e_instr;
    bit       e_err, e_lerr, e_inprog;
    bit [7:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(bit pm, bit le, bit [7:0] la, bit [7:0] ld,
                              bit rv, bit [7:0] ra, bit rr, bit e_rdy,
                              bit e_vld, bit [7:0] e_instr, bit e_err,
                              bit e_lerr, bit e_inprog, bit [7:0] e_cnt);
    vec_t v;
    v.pm = pm; v.le = le; v.la = la; v.ld = ld;
    v.rv = rv; v.ra = ra; v.rr = rr; v.e_rdy = e_rdy;
    v.e_vld = e_vld; v.e_instr = e_instr; v.e_err = e_err;
    v.e_lerr = e_lerr; v.e_inprog = e_inprog; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; req_ready is checked before
  // the next edge, registered outputs 1 unit after it.
  task automatic apply(input vec_t v, input string tag);
    prog_mode = v.pm; ld_en = v.le; ld_addr = v.la; ld_data = v.ld;
    req_valid = v.rv; req_addr = v.ra; rsp_ready = v.rr;
    #1;
    chk({tag, ".req_ready"}, req_ready, v.e_rdy);
    @(posedge clk); #1;
    chk({tag, ".rsp_valid"}, rsp_valid, v.e_vld);
    chk({tag, ".rsp_instr"}, rsp_instr, v.e_instr);
    chk({tag, ".rsp_err"},   rsp_err,   v.e_err);
    chk({tag, ".ld_err"},    ld_err,    v.e_lerr);
    chk({tag, ".in_prog"},   in_prog,   v.e_inprog);
    chk({tag, ".ld_count"},  ld_count,  v.e_cnt);
    n_vec++;
  endtask

  vec_t tbl[35];

  initial begin
    //          pm le la     ld     rv ra     rr rdy vld instr  err lerr prg cnt
    tbl[0]  = mk(1, 0, 8'd0,  8'h00, 0, 8'd0,  1, 1,  0, 8'h00, 0, 0, 1, 8'd0);
    tbl[1]  = mk(1, 1, 8'd0,  8'h69, 0, 8'd0,  1, 0,  0, 8'h00, 0, 0, 1, 8'd1);
    tbl[2]  = mk(1, 1, 8'd1,  8'h55, 0, 8'd0,  1, 0,  0, 8'h00, 0, 0, 1, 8'd2);
    tbl[3]  = mk(1, 1, 8'd2,  8'h6F, 0, 8'd0,  1, 0,  0, 8'h00, 0, 0, 1, 8'd3);
    tbl[4]  = mk(1, 1, 8'd3,  8'h2C, 0, 8'd0,  1, 0,  0, 8'h00, 0, 0, 1, 8'd4);
    tbl[5]  = mk(1, 1, 8'd4,  8'h91, 0, 8'd0,  1, 0,  0, 8'h00, 0, 0, 1, 8'd5);
    tbl[6]  = mk(0, 0, 8'd0,  8'h00, 0, 8'd0,  1, 0,  0, 8'h00, 0, 0, 0, 8'd5);
    tbl[7]  = mk(0, 0, 8'd0,  8'h00, 1, 8'd0,  1, 1,  1, 8'h69, 0, 0, 0, 8'd5);
    tbl[8]  = mk(0, 0, 8'd0,  8'h00, 1, 8'd1,  1, 1,  1, 8'h55, 0, 0, 0, 8'd5);
    tbl[9]  = mk(0, 0, 8'd0,  8'h00, 1, 8'd2,  1, 1,  1, 8'h6F, 0, 0, 0, 8'd5);
    tbl[10] = mk(0, 0, 8'd0,  8'h00, 1, 8'd3,  1, 1,  1, 8'h2C, 0, 0, 0, 8'd5);
    tbl[11] = mk(0, 0, 8'd0,  8'h00, 1, 8'd4,  1, 1,  1, 8'h91, 0, 0, 0, 8'd5);
    tbl[12] = mk(0, 0, 8'd0,  8'h00, 1, 8'd40, 1, 1,  1, 8'h00, 1, 0, 0, 8'd5);
    tbl[13] = mk(0, 0, 8'd0,  8'h00, 0, 8'd0,  1, 1,  0, 8'h00, 1, 0, 0, 8'd5);
    tbl[14] = mk(0, 0, 8'd0,  8'h00, 1, 8'd2,  0, 1,  1, 8'h6F, 0, 0, 0, 8'd5);
    tbl[15] = mk(0, 0, 8'd0,  8'h00, 1, 8'd3,  0, 0,  1, 8'h6F, 0, 0, 0, 8'd5);
    tbl[16] = mk(0, 0, 8'd0,  8'h00, 1, 8'd3,  0, 0,  1, 8'h6F, 0, 0, 0, 8'd5);
    tbl[17] = mk(0, 0, 8'd0,  8'h00, 1, 8'd3,  0, 0,  1, 8'h6F, 0, 0, 0, 8'd5);
    tbl[18] = mk(0, 0, 8'd0,  8'h00, 0, 8'd0,  1, 1,  0, 8'h6F, 0, 0, 0, 8'd5);
    tbl[19] = mk(0, 1, 8'd1,  8'hAA, 0, 8'd0,  1, 1,  0, 8'h6F, 0, 1, 0, 8'd5);
    tbl[20] = mk(0, 0, 8'd0,  8'h00, 0, 8'd0,  1, 1,  0, 8'h6F, 0, 0, 0, 8'd5);
    tbl[21] = mk(0, 0, 8'd0,  8'h00, 1, 8'd1,  1, 1,  1, 8'h55, 0, 0, 0, 8'd5);
    tbl[22] = mk(1, 0, 8'd0,  8'h00, 0, 8'd0,  0, 0,  1, 8'h55, 0, 0, 0, 8'd5);
    tbl[23] = mk(1, 0, 8'd0,  8'h00, 1, 8'd0,  0, 0,  1, 8'h55, 0, 0, 0, 8'd5);
    tbl[24] = mk(1, 0, 8'd0,  8'h00, 1, 8'd0,  1, 0,  0, 8'h55, 0, 0, 1, 8'd0);
    tbl[25] = mk(1, 1, 8'h20, 8'h77, 0, 8'd0,  1, 0,  0, 8'h55, 0, 1, 1, 8'd0);
    tbl[26] = mk(1, 1, 8'd31, 8'h3C, 0, 8'd0,  1, 0,  0, 8'h55, 0, 0, 1, 8'd1);
    tbl[27] = mk(0, 0, 8'd0,  8'h00, 0, 8'd0,  1, 0,  0, 8'h55, 0, 0, 0, 8'd1);
    tbl[28] = mk(0, 0, 8'd0,  8'h00, 1, 8'd31, 1, 1,  1, 8'h3C, 0, 0, 0, 8'd1);
    tbl[29] = mk(0, 0, 8'd0,  8'h00, 1, 8'd32, 1, 1,  1, 8'h00, 1, 0, 0, 8'd1);
    tbl[30] = mk(0, 0, 8'd0,  8'h00, 0, 8'd0,  1, 1,  0, 8'h00, 1, 0, 0, 8'd1);
    tbl[31] = mk(0, 0, 8'd0,  8'h00, 1, 8'd0,  0, 1,  1, 8'h69, 0, 0, 0, 8'd1);
    tbl[32] = mk(1, 0, 8'd0,  8'h00, 0, 8'd0,  0, 0,  1, 8'h69, 0, 0, 0, 8'd1);
    tbl[33] = mk(0, 0, 8'd0,  8'h00, 0, 8'd0,  0, 0,  1, 8'h69, 0, 0, 0, 8'd1);
    tbl[34] = mk(0, 0, 8'd0,  8'h00, 0, 8'd0,  1, 1,  0, 8'h69, 0, 0, 0, 8'd1);

    rst_n = 1'b0;
    prog_mode = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    #22 rst_n = 1'b1;
    @(posedge clk); #1;

    chk("reset.rsp_valid", rsp_valid, 1'b0);
    chk("reset.rsp_instr", rsp_instr, 8'h00);
    chk("reset.rsp_err",   rsp_err,   1'b0);
    chk("reset.ld_err",    ld_err,    1'b0);
    chk("reset.ld_count",  ld_count,  8'd0);
    chk("reset.in_prog",   in_prog,   1'b0);
    chk("reset.req_ready", req_ready, 1'b1);
    n_vec++;

    for (int i = 0; i < 35; i++) apply(tbl[i], $sformatf("v%0d", i));

    // Reset while in PROG after two loads: state and counters drop, memory persists.
    apply(mk(1, 0, 8'd0, 8'h00, 0, 8'd0, 1, 1, 0, 8'h69, 0, 0, 1, 8'd0), "rp0");
    apply(mk(1, 1, 8'd6, 8'hA1, 0, 8'd0, 1, 0, 0, 8'h69, 0, 0, 1, 8'd1), "rp1");
    apply(mk(1, 1, 8'd7, 8'hB2, 0, 8'd0, 1, 0, 0, 8'h69, 0, 0, 1, 8'd2), "rp2");
    ld_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_prog.in_prog",   in_prog,   1'b0);
    chk("rst_prog.rsp_valid", rsp_valid, 1'b0);
    chk("rst_prog.ld_count",  ld_count,  8'd0);
    chk("rst_prog.rsp_instr", rsp_instr, 8'h00);
    n_vec++;
    @(posedge clk); #1;
    prog_mode = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_prog.after_release.in_prog", in_prog, 1'b0);
    n_vec++;
    apply(mk(0, 0, 8'd0, 8'h00, 1, 8'd6, 1, 1, 1, 8'hA1, 0, 0, 0, 8'd0), "rp3");
    apply(mk(0, 0, 8'd0, 8'h00, 1, 8'd7, 1, 1, 1, 8'hB2, 0, 0, 0, 8'd0), "rp4");
    apply(mk(0, 0, 8'd0, 8'h00, 1, 8'd0, 1, 1, 1, 8'h69, 0, 0, 0, 8'd0), "rp5");
    apply(mk(0, 0, 8'd0, 8'h00, 1, 8'd4, 1, 1, 1, 8'h91, 0, 0, 0, 8'd0), "rp6");
    apply(mk(0, 0, 8'd0, 8'h00, 0, 8'd0, 1, 1, 0, 8'h91, 0, 0, 0, 8'd0), "rp7");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
